// File: rtl/seg_pipe_adder.sv
// Segmented, pipelined add/subtract unit with valid/ready handshakes.
//
// A DATA_W-bit operation is split into NUM_SEG = DATA_W/SEG_W segments. Stage k adds
// segment k of A and B' (B, or ~B when subtracting) plus the carry registered by stage
// k-1. Only one registered carry bit crosses each stage boundary. The operands and the
// partial sum travel alongside the carry. A beat presented in cycle 0 is visible on the
// output after NUM_SEG rising edges.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  input beat handshake; in_ready = !out_valid || out_ready
//   A, B                 unsigned operands, DATA_W bits
//   Carry                carry-in, used in add mode only
//   sub                  0 = A + B + Carry, 1 = A + ~B + 1
//   out_valid/out_ready  result handshake; the result holds while stalled
//   X                    {carry-out, sum}; X[DATA_W] = 1 means no borrow on subtract
//   ovf                  signed two's-complement overflow of the result
//
// DATA_W must be an integer multiple of SEG_W.
module seg_pipe_adder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Carry,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   X,
  output logic              ovf
);

  localparam int unsigned NUM_SEG = DATA_W / SEG_W;
  localparam int unsigned LAST    = NUM_SEG - 1;

  // Stage register outputs, exported so that each stage can read its predecessor.
  logic [NUM_SEG-1:0]             vld;
  logic [NUM_SEG-1:0]             cry;
  logic [NUM_SEG-1:0][DATA_W-1:0] opa;
  logic [NUM_SEG-1:0][DATA_W-1:0] opb;
  logic [NUM_SEG-1:0][DATA_W-1:0] sum;

  // A single global enable: the whole pipe advances, or the whole pipe holds.
  logic adv;
  assign adv      = ~vld[LAST] | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    logic              v_in, c_in;
    logic [DATA_W-1:0] a_in, b_in, s_in;
    logic [SEG_W:0]    seg_sum;
    logic              v_d, v_q, c_d, c_q;
    logic [DATA_W-1:0] a_d, a_q, b_d, b_q, s_d, s_q;

    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign a_in = A;
      assign b_in = sub ? ~B : B;
      // Subtraction supplies the +1 of the two's complement through the carry-in.
      assign c_in = sub | Carry;
      assign s_in = '0;
    end else begin : g_body
      assign v_in = vld[k-1];
      assign a_in = opa[k-1];
      assign b_in = opb[k-1];
      assign c_in = cry[k-1];
      assign s_in = sum[k-1];
    end

    assign seg_sum = {1'b0, a_in[k*SEG_W +: SEG_W]} + {1'b0, b_in[k*SEG_W +: SEG_W]}
                   + {{SEG_W{1'b0}}, c_in};

    // Data registers only load on a valid beat; bubbles leave them holding.
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      a_d = a_q;
      b_d = b_q;
      s_d = s_q;
      if (adv) begin
        v_d = v_in;
        if (v_in) begin
          c_d = seg_sum[SEG_W];
          a_d = a_in;
          b_d = b_in;
          s_d = s_in;
          s_d[k*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
      end
    end

    assign vld[k] = v_q;
    assign cry[k] = c_q;
    assign opa[k] = a_q;
    assign opb[k] = b_q;
    assign sum[k] = s_q;
  end

  assign out_valid = vld[LAST];
  assign X         = {cry[LAST], sum[LAST]};
  // Overflow: both operand signs agree, but the sum's sign differs from them.
  assign ovf       = (opa[LAST][DATA_W-1] == opb[LAST][DATA_W-1]) &&
                     (sum[LAST][DATA_W-1] != opa[LAST][DATA_W-1]);

  // Only the sign bits of the final operand copies feed logic; the rest is pruned.
  logic unused_op;
  assign unused_op = ^{opa[LAST][DATA_W-2:0], opb[LAST][DATA_W-2:0]};

endmodule

// File: tb/tb_seg_pipe_adder.sv
module tb_seg_pipe_adder;

  typedef longint unsigned u64_t;
  typedef struct {
    u64_t x;
    bit   o;
  } exp_t;

  logic clk;
  logic rst_n;

  // Default configuration: 8 bits, two 4-bit segments.
  logic       i8_valid, i8_ready, c8, s8, o8_valid, o8_ready, ovf8;
  logic [7:0] a8, b8;
  logic [8:0] x8;

  // Wide configuration: 32 bits, four 8-bit segments.
  logic        i32_valid, i32_ready, c32, s32, o32_valid, o32_ready, ovf32;
  logic [31:0] a32, b32;
  logic [32:0] x32;

  seg_pipe_adder #(.DATA_W(8), .SEG_W(4)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (i8_valid),
    .in_ready (i8_ready),
    .A        (a8),
    .B        (b8),
    .Carry    (c8),
    .sub      (s8),
    .out_valid(o8_valid),
    .out_ready(o8_ready),
    .X        (x8),
    .ovf      (ovf8)
  );

  seg_pipe_adder #(.DATA_W(32), .SEG_W(8)) u_dut32 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (i32_valid),
    .in_ready (i32_ready),
    .A        (a32),
    .B        (b32),
    .Carry    (c32),
    .sub      (s32),
    .out_valid(o32_valid),
    .out_ready(o32_ready),
    .X        (x32),
    .ovf      (ovf32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t q8[$];
  exp_t q32[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input u64_t act, input u64_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int unsigned w, input u64_t a, input u64_t b,
                                 input bit c, input bit s);
    exp_t   r;
    u64_t   full;
    longint sa, sb, sr, lim;
    full = u64_t'(1) << w;
    lim  = longint'(1) << (w - 1);
    sa   = (a >= (full >> 1)) ? longint'(a) - longint'(full) : longint'(a);
    sb   = (b >= (full >> 1)) ? longint'(b) - longint'(full) : longint'(b);
    if (s) begin
      r.x = ((a - b) & (full - 64'd1)) | ((a >= b) ? full : 64'd0);
      sr  = sa - sb;
    end else begin
      r.x = a + b + u64_t'(c);
      sr  = sa + sb + longint'(c);
    end
    r.o = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  // Monitors: compare on every consumed result, check holding while stalled.
  bit         hold8, hold32;
  logic [8:0] hx8;
  logic [32:0] hx32;
  logic       ho8, ho32;

  initial begin : mon8
    exp_t e;
    hold8 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold8 = 1'b0;
      end else begin
        chk("in_ready8", u64_t'(i8_ready), u64_t'(!o8_valid || o8_ready));
        if (hold8) begin
          chk("hold_valid8", u64_t'(o8_valid), 64'd1);
          chk("hold_x8", u64_t'(x8), u64_t'(hx8));
          chk("hold_ovf8", u64_t'(ovf8), u64_t'(ho8));
        end
        if (o8_valid && o8_ready) begin
          if (q8.size() == 0) begin
            fail_now("unexpected_out8", $sformatf("X=0x%0h with nothing outstanding", x8));
          end else begin
            e = q8.pop_front();
            chk("x8", u64_t'(x8), e.x);
            chk("ovf8", u64_t'(ovf8), u64_t'(e.o));
          end
        end
        hold8 = o8_valid && !o8_ready;
        hx8   = x8;
        ho8   = ovf8;
      end
    end
  end

  initial begin : mon32
    exp_t e;
    hold32 = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold32 = 1'b0;
      end else begin
        chk("in_ready32", u64_t'(i32_ready), u64_t'(!o32_valid || o32_ready));
        if (hold32) begin
          chk("hold_valid32", u64_t'(o32_valid), 64'd1);
          chk("hold_x32", u64_t'(x32), u64_t'(hx32));
          chk("hold_ovf32", u64_t'(ovf32), u64_t'(ho32));
        end
        if (o32_valid && o32_ready) begin
          if (q32.size() == 0) begin
            fail_now("unexpected_out32", $sformatf("X=0x%0h with nothing outstanding", x32));
          end else begin
            e = q32.pop_front();
            chk("x32", u64_t'(x32), e.x);
            chk("ovf32", u64_t'(ovf32), u64_t'(e.o));
          end
        end
        hold32 = o32_valid && !o32_ready;
        hx32   = x32;
        ho32   = ovf32;
      end
    end
  end

  // Present one beat; push its expectation when the handshake will complete.
  // Called at posedge+1, returns at posedge+1 just after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic s, input exp_t e);
    int n    = 0;
    bit done = 1'b0;
    a8 = a; b8 = b; c8 = c; s8 = s; i8_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (i8_ready) begin
        q8.push_back(e);
        done = 1'b1;
      end else if (++n > 100) begin
        fail_now("accept8_timeout", "in_ready never asserted");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    i8_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s);
    int n    = 0;
    bit done = 1'b0;
    a32 = a; b32 = b; c32 = c; s32 = s; i32_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (i32_ready) begin
        q32.push_back(model(32, u64_t'(a), u64_t'(b), c, s));
        done = 1'b1;
      end else if (++n > 100) begin
        fail_now("accept32_timeout", "in_ready never asserted");
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    i32_valid = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain8_left", u64_t'(q8.size()), 64'd0);
  endtask

  task automatic drain32();
    int n = 0;
    while (q32.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain32_left", u64_t'(q32.size()), 64'd0);
  endtask

  logic [7:0] ra8, rb8;
  logic       rc8, rs8;
  int         lat, sent, cyc;
  bit         acc;
  exp_t       d;

  initial begin : main
    rst_n = 1'b0;
    i8_valid = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; s8 = 1'b0; o8_ready = 1'b1;
    i32_valid = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0; s32 = 1'b0; o32_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid8", u64_t'(o8_valid), 64'd0);
    chk("rst_x8", u64_t'(x8), 64'd0);
    chk("rst_ovf8", u64_t'(ovf8), 64'd0);
    chk("rst_in_ready8", u64_t'(i8_ready), 64'd1);
    chk("rst_out_valid32", u64_t'(o32_valid), 64'd0);
    chk("rst_x32", u64_t'(x32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: two rising edges from presenting the beat to out_valid.
    d.x = 64'h04B; d.o = 1'b0;
    send8(8'h3C, 8'h0F, 1'b0, 1'b0, d);
    lat = 1;
    while (!o8_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency8", u64_t'(lat), 64'd2);
    drain8();

    // Directed vectors, back to back.
    d.x = 64'h1FF; d.o = 1'b0; send8(8'hFF, 8'hFF, 1'b1, 1'b0, d);
    d.x = 64'h080; d.o = 1'b1; send8(8'h7F, 8'h01, 1'b0, 1'b0, d);
    d.x = 64'h0F0; d.o = 1'b0; send8(8'h10, 8'h20, 1'b0, 1'b1, d);
    d.x = 64'h17F; d.o = 1'b1; send8(8'h80, 8'h01, 1'b1, 1'b1, d);
    d.x = 64'h100; d.o = 1'b0; send8(8'h5A, 8'h5A, 1'b1, 1'b1, d);
    d.x = 64'h000; d.o = 1'b0; send8(8'h00, 8'h00, 1'b0, 1'b0, d);
    d.x = 64'h100; d.o = 1'b0; send8(8'h01, 8'hFF, 1'b0, 1'b0, d);
    drain8();

    // Six beats streamed while the consumer stalls for four edges.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra8 = 8'($urandom); rb8 = 8'($urandom);
          rc8 = 1'($urandom); rs8 = 1'($urandom);
          send8(ra8, rb8, rc8, rs8, model(8, u64_t'(ra8), u64_t'(rb8), rc8, rs8));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        o8_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stall_in_ready8", u64_t'(i8_ready), 64'd0);
          chk("stall_out_valid8", u64_t'(o8_valid), 64'd1);
          @(posedge clk);
          #1;
        end
        o8_ready = 1'b1;
      end
    join
    drain8();

    // Reset between edges with two beats in flight.
    d.x = 64'h003; d.o = 1'b0; send8(8'h01, 8'h02, 1'b0, 1'b0, d);
    d.x = 64'h007; d.o = 1'b0; send8(8'h03, 8'h04, 1'b0, 1'b0, d);
    chk("pre_reset_valid8", u64_t'(o8_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    q8.delete();
    q32.delete();
    #1;
    chk("mid_rst_out_valid8", u64_t'(o8_valid), 64'd0);
    chk("mid_rst_x8", u64_t'(x8), 64'd0);
    chk("mid_rst_ovf8", u64_t'(ovf8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_reset_valid8", u64_t'(o8_valid), 64'd0);

    // Wide configuration: latency four, boundary values, then random traffic.
    send32(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    lat = 1;
    while (!o32_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency32", u64_t'(lat), 64'd4);
    drain32();
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    send32(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send32(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    drain32();

    sent = 0; cyc = 0; acc = 1'b0;
    while (sent < 10000 && cyc < 80000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (acc) i32_valid = 1'b0;
      acc = 1'b0;
      o32_ready = ($urandom_range(0, 3) != 0);
      if (!i32_valid && $urandom_range(0, 3) != 0) begin
        a32 = $urandom;
        b32 = $urandom;
        case ($urandom_range(0, 7))
          0:       begin a32 = '1; b32 = '1; end
          1:       b32 = a32;
          default: ;
        endcase
        c32 = 1'($urandom);
        s32 = 1'($urandom);
        i32_valid = 1'b1;
      end
      @(negedge clk);
      if (i32_valid && i32_ready) begin
        q32.push_back(model(32, u64_t'(a32), u64_t'(b32), c32, s32));
        sent++;
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    i32_valid = 1'b0;
    o32_ready = 1'b1;
    chk("random_beats32", u64_t'(sent), 64'd10000);
    drain32();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
